// File: rtl/estacao_reserva.sv
// estacao_reserva -- four-entry reservation station for one functional unit.
//
// Instructions are issued with their operand values or with the producer
// tags they still wait on. Pending operands are captured from the result
// broadcast bus (CDB). Entries with all operands available are dispatched
// to the functional unit one at a time, lowest index first. Dispatch pulses
// are never back to back, because the unit takes a cycle to lower its
// availability flag.
//
// Optional feature (macro RS_WAKEUP_BYPASS_EN):
//   defined   -> an entry whose last pending operand is broadcast this cycle
//                may dispatch in the same cycle; cdb_data is forwarded
//                straight to the dispatch outputs.
//   undefined -> only READY entries dispatch; wakeup costs one extra cycle.
//
// Ports:
//   clock, resetn                    system clock, async active-low reset
//   issue_valid / issue_ready        issue handshake (ready is combinational)
//   issue_instr, issue_tag           instruction (opcode in [3:0]) and result tag
//   issue_vj/vk, issue_qj/qk         operand values and producer tags
//   issue_qj_valid/qk_valid          1 = operand still pending on qj/qk
//   cdb_valid, cdb_tag, cdb_data     result broadcast
//   uf_disponivel                    functional unit available
//   uf_instruct                      registered one-cycle dispatch pulse
//   uf_instruction, uf_code          dispatched instruction and tag
//   uf_reg2, uf_reg1                 dispatched Vj and Vk (sub computes Vj-Vk)
//   occupancy                        number of non-FREE entries, 0..4
//
// Entry states:
//   state     | meaning
//   ENT_FREE  | slot empty, available for issue
//   ENT_WAIT  | holds an instruction with at least one pending operand
//   ENT_READY | all operands valid, waiting for dispatch

module estacao_reserva (
    input  logic        clock,
    input  logic        resetn,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [15:0] issue_instr,
    input  logic [2:0]  issue_tag,
    input  logic [15:0] issue_vj,
    input  logic [15:0] issue_vk,
    input  logic [2:0]  issue_qj,
    input  logic [2:0]  issue_qk,
    input  logic        issue_qj_valid,
    input  logic        issue_qk_valid,
    input  logic        cdb_valid,
    input  logic [2:0]  cdb_tag,
    input  logic [15:0] cdb_data,
    input  logic        uf_disponivel,
    output logic        uf_instruct,
    output logic [15:0] uf_instruction,
    output logic [2:0]  uf_code,
    output logic [15:0] uf_reg2,
    output logic [15:0] uf_reg1,
    output logic [2:0]  occupancy
);

    localparam int NUM_ENT = 4;

    typedef enum logic [1:0] {
        ENT_FREE  = 2'd0,
        ENT_WAIT  = 2'd1,
        ENT_READY = 2'd2
    } ent_state_t;

    typedef struct packed {
        ent_state_t  state;
        logic [15:0] instr;
        logic [2:0]  tag;
        logic [15:0] vj;
        logic [15:0] vk;
        logic [2:0]  qj;
        logic [2:0]  qk;
        logic        pj;
        logic        pk;
    } entry_t;

    entry_t ent_q [NUM_ENT];
    entry_t ent_d [NUM_ENT];

    logic [NUM_ENT-1:0] free_vec;
    logic [NUM_ENT-1:0] elig;
    logic [NUM_ENT-1:0] wake_j;
    logic [NUM_ENT-1:0] wake_k;
    logic [1:0]         issue_sel;
    logic [1:0]         disp_sel;
    logic               issue_go;
    logic               disp_go;
    logic               iss_wake_j;
    logic               iss_wake_k;
    logic [15:0]        disp_vj;
    logic [15:0]        disp_vk;

    // Wakeup, eligibility and lowest-index selection, all from pre-edge state.
    // Iterating downwards leaves the lowest matching index in the selectors.
    always_comb begin
        free_vec  = '0;
        elig      = '0;
        wake_j    = '0;
        wake_k    = '0;
        issue_sel = '0;
        disp_sel  = '0;
        for (int i = NUM_ENT - 1; i >= 0; i--) begin
            free_vec[i] = (ent_q[i].state == ENT_FREE);
            wake_j[i]   = ent_q[i].pj && cdb_valid && (ent_q[i].qj == cdb_tag);
            wake_k[i]   = ent_q[i].pk && cdb_valid && (ent_q[i].qk == cdb_tag);
`ifdef RS_WAKEUP_BYPASS_EN
            elig[i] = (ent_q[i].state == ENT_READY) ||
                      ((ent_q[i].state == ENT_WAIT) &&
                       (!ent_q[i].pj || wake_j[i]) &&
                       (!ent_q[i].pk || wake_k[i]));
`else
            elig[i] = (ent_q[i].state == ENT_READY);
`endif
            if (free_vec[i]) issue_sel = 2'(i);
            if (elig[i])     disp_sel  = 2'(i);
        end
        issue_ready = |free_vec;
        issue_go    = issue_valid && issue_ready;
        // The previous pulse masks this cycle: the unit's availability flag
        // lags the pulse by one cycle.
        disp_go     = uf_disponivel && !uf_instruct && (|elig);
    end

    // Operand values for the dispatched entry.
    always_comb begin
        disp_vj = ent_q[disp_sel].vj;
        disp_vk = ent_q[disp_sel].vk;
`ifdef RS_WAKEUP_BYPASS_EN
        if (wake_j[disp_sel]) disp_vj = cdb_data;
        if (wake_k[disp_sel]) disp_vk = cdb_data;
`endif
    end

    // Per-entry next state: CDB capture, dispatch release, issue load.
    // Dispatch and issue never hit the same entry (dispatch needs a non-FREE
    // entry, issue a FREE one), so their order here does not matter.
    always_comb begin
        iss_wake_j = issue_qj_valid && cdb_valid && (issue_qj == cdb_tag);
        iss_wake_k = issue_qk_valid && cdb_valid && (issue_qk == cdb_tag);
        for (int i = 0; i < NUM_ENT; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].state == ENT_WAIT) begin
                if (wake_j[i]) begin
                    ent_d[i].vj = cdb_data;
                    ent_d[i].pj = 1'b0;
                end
                if (wake_k[i]) begin
                    ent_d[i].vk = cdb_data;
                    ent_d[i].pk = 1'b0;
                end
                if (!ent_d[i].pj && !ent_d[i].pk) begin
                    ent_d[i].state = ENT_READY;
                end
            end
            if (disp_go && (disp_sel == 2'(i))) begin
                ent_d[i].state = ENT_FREE;
                ent_d[i].pj    = 1'b0;
                ent_d[i].pk    = 1'b0;
            end
            if (issue_go && (issue_sel == 2'(i))) begin
                ent_d[i].instr = issue_instr;
                ent_d[i].tag   = issue_tag;
                ent_d[i].qj    = issue_qj;
                ent_d[i].qk    = issue_qk;
                // A same-cycle broadcast of the producer wins over issue_v*.
                ent_d[i].vj    = iss_wake_j ? cdb_data : issue_vj;
                ent_d[i].vk    = iss_wake_k ? cdb_data : issue_vk;
                ent_d[i].pj    = issue_qj_valid && !iss_wake_j;
                ent_d[i].pk    = issue_qk_valid && !iss_wake_k;
                ent_d[i].state = (ent_d[i].pj || ent_d[i].pk) ? ENT_WAIT : ENT_READY;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENT; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            uf_instruct    <= 1'b0;
            uf_instruction <= '0;
            uf_code        <= '0;
            uf_reg2        <= '0;
            uf_reg1        <= '0;
            occupancy      <= '0;
        end else begin
            uf_instruct <= disp_go;
            if (disp_go) begin
                uf_instruction <= ent_q[disp_sel].instr;
                uf_code        <= ent_q[disp_sel].tag;
                uf_reg2        <= disp_vj;
                uf_reg1        <= disp_vk;
            end
            occupancy <= occupancy + 3'(issue_go) - 3'(disp_go);
        end
    end

endmodule

// File: tb/tb_estacao_reserva.sv
module tb_estacao_reserva;

    logic        clock;
    logic        resetn;
    logic        issue_valid;
    logic        issue_ready;
    logic [15:0] issue_instr;
    logic [2:0]  issue_tag;
    logic [15:0] issue_vj;
    logic [15:0] issue_vk;
    logic [2:0]  issue_qj;
    logic [2:0]  issue_qk;
    logic        issue_qj_valid;
    logic        issue_qk_valid;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [15:0] cdb_data;
    logic        uf_disponivel;
    logic        uf_instruct;
    logic [15:0] uf_instruction;
    logic [2:0]  uf_code;
    logic [15:0] uf_reg2;
    logic [15:0] uf_reg1;
    logic [2:0]  occupancy;

    int compared = 0;
    int mismatched = 0;

    // Drain schedule for test_back_to_back (edges 1..10).
    logic       bb_pulse [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] bb_code  [10] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd6, 3'd0, 3'd2, 3'd0, 3'd3, 3'd0};
    logic [15:0] bb_reg2 [10] = '{16'd10, 16'd0, 16'd11, 16'd0, 16'd99, 16'd0, 16'd12, 16'd0, 16'd13, 16'd0};
    logic [15:0] bb_reg1 [10] = '{16'd20, 16'd0, 16'd21, 16'd0, 16'd98, 16'd0, 16'd22, 16'd0, 16'd23, 16'd0};
    logic [2:0]  bb_occ  [10] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};

    estacao_reserva dut (
        .clock          (clock),
        .resetn         (resetn),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_instr    (issue_instr),
        .issue_tag      (issue_tag),
        .issue_vj       (issue_vj),
        .issue_vk       (issue_vk),
        .issue_qj       (issue_qj),
        .issue_qk       (issue_qk),
        .issue_qj_valid (issue_qj_valid),
        .issue_qk_valid (issue_qk_valid),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .uf_disponivel  (uf_disponivel),
        .uf_instruct    (uf_instruct),
        .uf_instruction (uf_instruction),
        .uf_code        (uf_code),
        .uf_reg2        (uf_reg2),
        .uf_reg1        (uf_reg1),
        .occupancy      (occupancy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_issue(input logic [15:0] instr, input logic [2:0] tag,
                               input logic [15:0] vj, input logic [15:0] vk,
                               input logic [2:0] qj, input logic [2:0] qk,
                               input logic pj, input logic pk);
        issue_valid    = 1'b1;
        issue_instr    = instr;
        issue_tag      = tag;
        issue_vj       = vj;
        issue_vk       = vk;
        issue_qj       = qj;
        issue_qk       = qk;
        issue_qj_valid = pj;
        issue_qk_valid = pk;
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        #1;
        compared++; if (issue_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %0h want 1", issue_ready); end
        compared++; if (occupancy !== 3'd0) begin mismatched++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        compared++; if (uf_instruct !== 1'b0) begin mismatched++; $display("FAIL reset_instruct: got %0h want 0", uf_instruct); end
        compared++; if (uf_instruction !== 16'h0) begin mismatched++; $display("FAIL reset_instruction: got %0h want 0", uf_instruction); end
        compared++; if (uf_code !== 3'd0) begin mismatched++; $display("FAIL reset_code: got %0h want 0", uf_code); end
        compared++; if (uf_reg2 !== 16'h0 || uf_reg1 !== 16'h0) begin mismatched++; $display("FAIL reset_regs: got %0h/%0h want 0/0", uf_reg2, uf_reg1); end
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        uf_disponivel = 1'b1;
        drive_issue(16'h0000, 3'd3, 16'd5, 16'd7, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        compared++; if (occupancy !== 3'd1) begin mismatched++; $display("FAIL add_occ_issue: got %0d want 1", occupancy); end
        compared++; if (uf_instruct !== 1'b0) begin mismatched++; $display("FAIL add_no_early_dispatch: got %0h want 0", uf_instruct); end
        issue_valid = 1'b0;
        tick();
        compared++; if (uf_instruct !== 1'b1) begin mismatched++; $display("FAIL add_pulse: got %0h want 1", uf_instruct); end
        compared++; if (uf_code !== 3'd3) begin mismatched++; $display("FAIL add_code: got %0h want 3", uf_code); end
        compared++; if (uf_reg2 !== 16'd5 || uf_reg1 !== 16'd7) begin mismatched++; $display("FAIL add_regs: got %0h/%0h want 5/7", uf_reg2, uf_reg1); end
        compared++; if (uf_instruction !== 16'h0000) begin mismatched++; $display("FAIL add_instr: got %0h want 0", uf_instruction); end
        compared++; if (occupancy !== 3'd0) begin mismatched++; $display("FAIL add_occ_after: got %0d want 0", occupancy); end
        tick();
        compared++; if (uf_instruct !== 1'b0) begin mismatched++; $display("FAIL add_pulse_end: got %0h want 0", uf_instruct); end
        compared++; if (uf_reg2 !== 16'd5 || uf_code !== 3'd3) begin mismatched++; $display("FAIL add_hold: got %0h/%0h want 5/3", uf_reg2, uf_code); end
    endtask

    task automatic test_wakeup();
        uf_disponivel = 1'b1;
        drive_issue(16'h0001, 3'd1, 16'hDEAD, 16'd4, 3'd2, 3'd0, 1'b1, 1'b0);
        tick();
        compared++; if (occupancy !== 3'd1) begin mismatched++; $display("FAIL wake_occ_issue: got %0d want 1", occupancy); end
        compared++; if (uf_instruct !== 1'b0) begin mismatched++; $display("FAIL wake_no_dispatch_pending: got %0h want 0", uf_instruct); end
        issue_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 16'd20;
        tick();
        cdb_valid = 1'b0;
`ifdef RS_WAKEUP_BYPASS_EN
        compared++; if (uf_instruct !== 1'b1) begin mismatched++; $display("FAIL wake_bypass_pulse: got %0h want 1", uf_instruct); end
        compared++; if (uf_reg2 !== 16'd20 || uf_reg1 !== 16'd4 || uf_code !== 3'd1) begin mismatched++; $display("FAIL wake_bypass_data: got %0h/%0h/%0h want 14/4/1", uf_reg2, uf_reg1, uf_code); end
        tick();
        compared++; if (uf_instruct !== 1'b0 || occupancy !== 3'd0) begin mismatched++; $display("FAIL wake_bypass_after: got %0h/%0d want 0/0", uf_instruct, occupancy); end
`else
        compared++; if (uf_instruct !== 1'b0 || occupancy !== 3'd1) begin mismatched++; $display("FAIL wake_cdb_edge: got %0h/%0d want 0/1", uf_instruct, occupancy); end
        tick();
        compared++; if (uf_instruct !== 1'b1) begin mismatched++; $display("FAIL wake_pulse: got %0h want 1", uf_instruct); end
        compared++; if (uf_reg2 !== 16'd20 || uf_reg1 !== 16'd4 || uf_code !== 3'd1) begin mismatched++; $display("FAIL wake_data: got %0h/%0h/%0h want 14/4/1", uf_reg2, uf_reg1, uf_code); end
        compared++; if (uf_instruction !== 16'h0001 || occupancy !== 3'd0) begin mismatched++; $display("FAIL wake_instr_occ: got %0h/%0d want 1/0", uf_instruction, occupancy); end
        tick();
`endif
    endtask

    task automatic test_dual_wake();
        uf_disponivel = 1'b1;
        drive_issue(16'h0000, 3'd2, 16'hFFFF, 16'hFFFF, 3'd6, 3'd6, 1'b1, 1'b1);
        tick();
        issue_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 3'd7; cdb_data = 16'h0055;
        tick();
        compared++; if (uf_instruct !== 1'b0 || occupancy !== 3'd1) begin mismatched++; $display("FAIL dual_wrong_tag: got %0h/%0d want 0/1", uf_instruct, occupancy); end
        cdb_tag = 3'd6; cdb_data = 16'h0033;
        tick();
        cdb_valid = 1'b0;
`ifndef RS_WAKEUP_BYPASS_EN
        compared++; if (uf_instruct !== 1'b0) begin mismatched++; $display("FAIL dual_cdb_edge: got %0h want 0", uf_instruct); end
        tick();
`endif
        compared++; if (uf_instruct !== 1'b1 || uf_code !== 3'd2) begin mismatched++; $display("FAIL dual_pulse: got %0h/%0h want 1/2", uf_instruct, uf_code); end
        compared++; if (uf_reg2 !== 16'h0033 || uf_reg1 !== 16'h0033) begin mismatched++; $display("FAIL dual_data: got %0h/%0h want 33/33", uf_reg2, uf_reg1); end
        tick();
    endtask

    task automatic test_full();
        uf_disponivel = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_issue(16'h0004, 3'(i), 16'(10 + i), 16'(20 + i), 3'd0, 3'd0, 1'b0, 1'b0);
            tick();
            compared++; if (occupancy !== 3'(i + 1)) begin mismatched++; $display("FAIL full_occ_%0d: got %0d want %0d", i, occupancy, i + 1); end
        end
        compared++; if (issue_ready !== 1'b0) begin mismatched++; $display("FAIL full_ready: got %0h want 0", issue_ready); end
        drive_issue(16'h0000, 3'd7, 16'd77, 16'd77, 3'd0, 3'd0, 1'b0, 1'b0);
        tick();
        issue_valid = 1'b0;
        compared++; if (occupancy !== 3'd4 || issue_ready !== 1'b0) begin mismatched++; $display("FAIL full_fifth_ignored: got %0d/%0h want 4/0", occupancy, issue_ready); end
        compared++; if (uf_instruct !== 1'b0) begin mismatched++; $display("FAIL full_no_dispatch: got %0h want 0", uf_instruct); end
    endtask

    // Drains the four entries left by test_full; a new issue lands in freed
    // entry 0 at edge 3 (together with a dispatch) and, being lowest index,
    // goes out at edge 5 ahead of entries 2 and 3.
    task automatic test_back_to_back();
        uf_disponivel = 1'b1;
        for (int e = 0; e < 10; e++) begin
            if (e == 2) drive_issue(16'h0004, 3'd6, 16'd99, 16'd98, 3'd0, 3'd0, 1'b0, 1'b0);
            else issue_valid = 1'b0;
            tick();
            compared++; if (uf_instruct !== bb_pulse[e]) begin mismatched++; $display("FAIL b2b_pulse_e%0d: got %0h want %0h", e + 1, uf_instruct, bb_pulse[e]); end
            compared++; if (occupancy !== bb_occ[e]) begin mismatched++; $display("FAIL b2b_occ_e%0d: got %0d want %0d", e + 1, occupancy, bb_occ[e]); end
            if (bb_pulse[e]) begin
                compared++;
                if (uf_code !== bb_code[e] || uf_reg2 !== bb_reg2[e] || uf_reg1 !== bb_reg1[e]) begin
                    mismatched++;
                    $display("FAIL b2b_data_e%0d: got %0h/%0h/%0h want %0h/%0h/%0h", e + 1, uf_code, uf_reg2, uf_reg1, bb_code[e], bb_reg2[e], bb_reg1[e]);
                end
            end
            if (e == 0) begin
                compared++; if (issue_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready_after_free: got %0h want 1", issue_ready); end
            end
        end
        compared++; if (uf_reg2 !== 16'd13) begin mismatched++; $display("FAIL b2b_hold: got %0h want d", uf_reg2); end
    endtask

    task automatic test_same_cycle_capture();
        uf_disponivel = 1'b0;
        drive_issue(16'h0001, 3'd4, 16'hAAAA, 16'hAAAA, 3'd5, 3'd5, 1'b1, 1'b1);
        cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'd9;
        tick();
        issue_valid = 1'b0;
        cdb_valid = 1'b0;
        compared++; if (occupancy !== 3'd1) begin mismatched++; $display("FAIL same_occ: got %0d want 1", occupancy); end
        uf_disponivel = 1'b1;
        tick();
        compared++; if (uf_instruct !== 1'b1 || uf_code !== 3'd4) begin mismatched++; $display("FAIL same_pulse: got %0h/%0h want 1/4", uf_instruct, uf_code); end
        compared++; if (uf_reg2 !== 16'd9 || uf_reg1 !== 16'd9) begin mismatched++; $display("FAIL same_data: got %0h/%0h want 9/9", uf_reg2, uf_reg1); end
        tick();
    endtask

    task automatic test_reset_midop();
        uf_disponivel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_issue(16'h0000, 3'(i + 1), 16'(i + 1), 16'(i + 2), 3'd0, 3'd0, 1'b0, 1'b0);
            tick();
        end
        issue_valid = 1'b0;
        uf_disponivel = 1'b1;
        tick();
        compared++; if (uf_instruct !== 1'b1 || occupancy !== 3'd2) begin mismatched++; $display("FAIL midop_pre: got %0h/%0d want 1/2", uf_instruct, occupancy); end
        #2 resetn = 1'b0;
        #1;
        compared++; if (uf_instruct !== 1'b0) begin mismatched++; $display("FAIL midop_pulse_cut: got %0h want 0", uf_instruct); end
        compared++; if (occupancy !== 3'd0 || issue_ready !== 1'b1) begin mismatched++; $display("FAIL midop_state: got %0d/%0h want 0/1", occupancy, issue_ready); end
        compared++; if (uf_code !== 3'd0 || uf_reg2 !== 16'd0) begin mismatched++; $display("FAIL midop_data: got %0h/%0h want 0/0", uf_code, uf_reg2); end
        tick();
        resetn = 1'b1;
        tick();
        tick();
        compared++; if (uf_instruct !== 1'b0 || occupancy !== 3'd0) begin mismatched++; $display("FAIL midop_discarded: got %0h/%0d want 0/0", uf_instruct, occupancy); end
    endtask

    initial begin
        resetn = 1'b1;
        issue_valid = 1'b0;
        issue_instr = '0;
        issue_tag = '0;
        issue_vj = '0;
        issue_vk = '0;
        issue_qj = '0;
        issue_qk = '0;
        issue_qj_valid = 1'b0;
        issue_qk_valid = 1'b0;
        cdb_valid = 1'b0;
        cdb_tag = '0;
        cdb_data = '0;
        uf_disponivel = 1'b0;

        test_reset();
        test_single_add();
        test_wakeup();
        test_dual_wake();
        test_full();
        test_back_to_back();
        test_same_cycle_capture();
        test_reset_midop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/estacao_reserva.md
ESTACAO_RESERVA -- requirements
Module: estacao_reserva

Interface
REQ-001 clock  in  1  single system clock; all state changes on rising edge.
REQ-002 resetn  in  1  asynchronous, active-low reset.
REQ-003 issue_valid  in  1  issue request, qualified by issue_ready.
REQ-004 issue_ready  out  1  combinational; 1 when at least one entry is FREE.
REQ-005 issue_instr  in  16  instruction; opcode in [3:0] (0000 add, 0001 sub, 0100 mul, 0010/0011 ld/sd).
REQ-006 issue_tag  in  3  result tag carried to the functional unit.
REQ-007 issue_vj, issue_vk  in  16 each  source operand values.
REQ-008 issue_qj, issue_qk  in  3 each  producer tags.
REQ-009 issue_qj_valid, issue_qk_valid  in  1 each  1 = operand pending on the matching tag; 0 = value valid.
REQ-010 cdb_valid, cdb_tag, cdb_data  in  1/3/16  result broadcast, driven from the functional unit's done, code and data outputs.
REQ-011 uf_disponivel  in  1  functional unit available.
REQ-012 uf_instruct  out  1  registered one-cycle dispatch pulse.
REQ-013 uf_instruction  out  16  registered instruction for the functional unit.
REQ-014 uf_code  out  3  registered tag for the functional unit.
REQ-015 uf_reg2, uf_reg1  out  16 each  registered Vj and Vk, so sub computes Vj-Vk.
REQ-016 occupancy  out  3  number of non-FREE entries, 0..4.

Function
REQ-017 Four entries; each entry is in one of FREE, WAIT or READY.
REQ-018 Issue is accepted when issue_valid=1 and issue_ready=1; the entry is the lowest-index FREE entry.
- Target state is READY if no operand is pending, otherwise WAIT.
- issue_valid with issue_ready=0 is ignored; state does not change.
REQ-019 CDB capture: a pending operand whose tag equals cdb_tag while cdb_valid=1 takes cdb_data and clears its pending flag.
- A WAIT entry with no remaining pending operand becomes READY.
REQ-020 An issuing operand whose tag matches a CDB broadcast in the same cycle is captured from cdb_data, not from issue_v*.
REQ-021 One broadcast wakes every matching operand in every entry, including both operands of one entry.
REQ-022 Dispatch is allowed when all three conditions hold:
- uf_disponivel=1;
- uf_instruct was 0 in the previous cycle (cover for the functional unit's one-cycle availability latency);
- at least one entry is eligible.
REQ-023 Dispatch selects the lowest-index eligible entry.
- At the next edge: uf_instruct=1 for one cycle, uf_instruction/uf_code/uf_reg2/uf_reg1 are loaded, and the entry goes to FREE.
REQ-024 The data outputs hold their last values while uf_instruct=0.
REQ-025 An entry issued at edge N dispatches at edge N+1 at the earliest.
REQ-026 issue_ready and the issue selection use the pre-edge state; an entry freed by dispatch at an edge is reusable from the following cycle.
REQ-027 occupancy is updated each edge as +1 on issue and -1 on dispatch; simultaneous issue and dispatch leave it unchanged.

Reset
REQ-028 resetn=0 immediately sets all entries FREE, uf_instruct=0, the data outputs to 0 and occupancy=0, so issue_ready=1.
REQ-029 Reset mid-operation discards all entries; a dispatch pulse in flight is cut asynchronously.

Configuration
REQ-030 With RS_WAKEUP_BYPASS_EN defined, a WAIT entry is eligible in the cycle its last pending operand matches the CDB, and cdb_data is forwarded to the dispatch outputs.
REQ-031 Without RS_WAKEUP_BYPASS_EN, eligibility is READY entries only, so wakeup-to-dispatch takes one extra cycle.

Verification
REQ-032 Issue add, tag 3, Vj=5, Vk=7, both valid, uf_disponivel=1 -> next edge uf_instruct=1, uf_code=3, uf_reg2=5, uf_reg1=7, occupancy returns to 0.
REQ-033 Issue sub with qj=2 pending, then CDB tag 2, data 20, Vk=4:
- bypass enabled -> dispatch at the CDB edge with uf_reg2=20;
- bypass disabled -> dispatch one edge later.
REQ-034 Issue 4 entries while uf_disponivel=0 -> issue_ready=0, occupancy=4, a fifth issue is ignored.
REQ-035 Hold uf_disponivel=1 with 2 READY entries -> dispatch pulses are never on consecutive cycles; entry 0 is sent before entry 1.
REQ-036 Issue with qj=qk=5 in the same cycle as CDB tag 5, data 9 -> entry READY with both operands 9.
REQ-037 Pull resetn low while uf_instruct=1 with 3 entries held -> uf_instruct=0 immediately, occupancy=0, issue_ready=1.
